fwd_ctrl: RTL and testbench



---
 rtl/mips_fwd_pkg.sv | 23 ++
 rtl/fwd_ctrl_if.sv | 41 ++++
 rtl/fwd_src_match.sv | 38 +++
 rtl/fwd_ctrl.sv | 91 +++++++++
 tb/tb_fwd_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/mips_fwd_pkg.sv
// Shared types and select encodings for the EX-stage forwarding and load-use controller.
// The FWD_CTRL_STATS_EN macro enables the stall counter in the files that use this package.
package mips_fwd_pkg;

    localparam int FWD_REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Shadow of one in-flight instruction's destination.
    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [FWD_REG_W-1:0] wr_reg;
        logic                 is_load;
    } stage_t;

    function automatic logic stage_writes(input stage_t e);
        return e.valid & e.wr_en;
    endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage request and forwarding/stall response bundle for fwd_ctrl.
// stall_cnt exists only when FWD_CTRL_STATS_EN is defined.
interface fwd_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_reg;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
`ifdef FWD_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wr_en, id_wr_reg, id_is_load, flush,
        input  stall, fwd_a_sel, fwd_b_sel
`ifdef FWD_CTRL_STATS_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wr_en, id_wr_reg, id_is_load, flush,
        output stall, fwd_a_sel, fwd_b_sel
`ifdef FWD_CTRL_STATS_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/fwd_src_match.sv
// Compares one ID source register against the in-flight destinations and picks
// the operand select; also flags a hit on a load still in EX.
module fwd_src_match
    import mips_fwd_pkg::*;
#(
    parameter int REG_W = FWD_REG_W
) (
    input  logic             use_i,
    input  logic [REG_W-1:0] idx_i,
    input  stage_t           ex_i,
    input  stage_t           mem_i,
    input  stage_t           wb_i,
    output logic [1:0]       sel_o,
    output logic             load_hit_o
);

    logic ex_hit, mem_hit, wb_hit;

    function automatic logic src_hits(input logic used, input logic [REG_W-1:0] idx,
                                      input stage_t e);
        return used && (idx != '0) && stage_writes(e) && (e.wr_reg == FWD_REG_W'(idx));
    endfunction

    assign ex_hit     = src_hits(use_i, idx_i, ex_i);
    assign mem_hit    = src_hits(use_i, idx_i, mem_i);
    assign wb_hit     = src_hits(use_i, idx_i, wb_i);
    assign load_hit_o = ex_hit & ex_i.is_load;

    // Youngest producer wins; a WB producer is already visible through the
    // register file because it writes in the first half of the cycle.
    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit)       sel_o = FWD_EXMEM;
        else if (mem_hit) sel_o = FWD_MEMWB;
        else if (wb_hit)  sel_o = FWD_RF;
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Define FWD_CTRL_STATS_EN to add the saturating stall_cnt output.
module fwd_ctrl
    import mips_fwd_pkg::*;
#(
    parameter int REG_W = FWD_REG_W,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fwd_ctrl_if.slave     bus
);

    localparam int NUM_SRC = 2;

    stage_t ex_q, mem_q, wb_q, ex_d;

    logic [NUM_SRC-1:0][REG_W-1:0] src_idx;
    logic [NUM_SRC-1:0]            src_use;
    logic [NUM_SRC-1:0][1:0]       src_sel;
    logic [NUM_SRC-1:0]            src_ld;
    logic [NUM_SRC-1:0][1:0]       sel_q, sel_d;

    logic stall_c, issue_c;

    assign src_idx = {bus.id_rt, bus.id_rs};
    assign src_use = {bus.id_use_rt, bus.id_use_rs};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(.REG_W(REG_W)) u_match (
            .use_i      (src_use[s]),
            .idx_i      (src_idx[s]),
            .ex_i       (ex_q),
            .mem_i      (mem_q),
            .wb_i       (wb_q),
            .sel_o      (src_sel[s]),
            .load_hit_o (src_ld[s])
        );
    end

    // flush outranks stall, so a squashed instruction never requests a hold.
    assign stall_c = bus.id_valid & ~bus.flush & (|src_ld);
    assign issue_c = bus.id_valid & ~stall_c & ~bus.flush;

    always_comb begin
        ex_d  = '0;
        sel_d = {FWD_RF, FWD_RF};
        if (issue_c) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = bus.id_wr_en;
            ex_d.wr_reg  = FWD_REG_W'(bus.id_wr_reg);
            ex_d.is_load = bus.id_is_load;
            sel_d        = src_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sel_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            sel_q <= sel_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_a_sel = sel_q[0];
    assign bus.fwd_b_sel = sel_q[1];

`ifdef FWD_CTRL_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed scoreboard bench for fwd_ctrl: expected selects are queued when an
// instruction is presented in ID and compared once it occupies EX.
module tb_fwd_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fwd_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

    fwd_ctrl #(.REG_W(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input logic we, input int wr, input logic ld,
                         input logic fl);
        bus.id_valid   = v;
        bus.id_rs      = 5'(rs);
        bus.id_rt      = 5'(rt);
        bus.id_use_rs  = urs;
        bus.id_use_rt  = urt;
        bus.id_wr_en   = we;
        bus.id_wr_reg  = 5'(wr);
        bus.id_is_load = ld;
        bus.flush      = fl;
    endtask

    // Called just after a rising edge; checks stall mid-cycle and the selects
    // one cycle later, when the instruction is in EX.
    task automatic step(input string tag, input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input logic we, input int wr,
                        input logic ld, input logic fl, input logic es,
                        input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] e;
        drive(v, rs, rt, urs, urt, we, wr, ld, fl);
        sb_q.push_back({ea, eb});
        @(negedge clk);
        chk({tag, ".stall"}, 32'(bus.stall), 32'(es));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.sb: observed empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".a"}, 32'(bus.fwd_a_sel), 32'(e[3:2]));
            chk({tag, ".b"}, 32'(bus.fwd_b_sel), 32'(e[1:0]));
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.a", 32'(bus.fwd_a_sel), 32'd0);
        chk("rst.b", 32'(bus.fwd_b_sel), 32'd0);
`ifdef FWD_CTRL_STATS_EN
        chk("rst.cnt", 32'(bus.stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        // name   v rs rt urs urt we wr ld fl  stall a      b
        step("add_r3",   1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00);
        step("add_r4",   1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 2'b01, 2'b00);
        step("add_r3b",  1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00);
        step("nop1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("sub_r6",   1, 1, 3, 1, 1, 1, 6, 0, 0, 0, 2'b00, 2'b10);
        step("lw_r2",    1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 2'b00, 2'b00);
        step("lu_stall", 1, 2, 2, 1, 1, 1, 7, 0, 0, 1, 2'b00, 2'b00);
        step("lu_fwd",   1, 2, 2, 1, 1, 1, 7, 0, 0, 0, 2'b10, 2'b10);
`ifdef FWD_CTRL_STATS_EN
        chk("cnt_one", 32'(bus.stall_cnt), 32'd1);
`endif
        step("add_r0",   1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        step("lw_r0",    1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("rd_r0",    1, 0, 0, 1, 1, 1, 8, 0, 0, 0, 2'b00, 2'b00);
        step("add_r9a",  1, 1, 2, 1, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00);
        step("add_r9b",  1, 1, 2, 1, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00);
        step("ex_prio",  1, 9, 9, 1, 1, 1, 10, 0, 0, 0, 2'b01, 2'b01);
        step("nop2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("wb_mem",   1, 9, 10, 1, 1, 1, 11, 0, 0, 0, 2'b00, 2'b10);
        step("lw_r2b",   1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 2'b00, 2'b00);
        step("flush",    1, 2, 1, 1, 1, 1, 7, 0, 1, 0, 2'b00, 2'b00);
        step("post_fl",  1, 7, 2, 1, 1, 1, 12, 0, 0, 0, 2'b00, 2'b10);
        step("lw_r5",    1, 12, 0, 1, 0, 1, 5, 1, 0, 0, 2'b01, 2'b00);

        // Load-use pending in ID when reset hits mid-cycle.
        drive(1, 5, 5, 1, 1, 1, 6, 0, 0);
        #2;
        chk("pre_rst.stall", 32'(bus.stall), 32'd1);
        chk("pre_rst.a", 32'(bus.fwd_a_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.stall", 32'(bus.stall), 32'd0);
        chk("async_rst.a", 32'(bus.fwd_a_sel), 32'd0);
        chk("async_rst.b", 32'(bus.fwd_b_sel), 32'd0);
`ifdef FWD_CTRL_STATS_EN
        chk("async_rst.cnt", 32'(bus.stall_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 1, 5, 5, 1, 1, 1, 6, 0, 0, 0, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
